// File: rtl/instruction_fetch_pkg.sv
// Shared processor package: fetch FSM state encodings, datapath widths and
// the default reset PC.
package instruction_fetch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPCODE_W  = 6;
    localparam int unsigned JTARGET_W = 26;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESET_S = 2'd0,
        FETCH   = 2'd1,
        VALID   = 2'd2,
        ERROR   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection for the fetch stage.
//   pc_plus4_i      : address of the sequentially following instruction
//   jump_i          : take the jump target (highest priority)
//   pc_src_i        : branch taken
//   branch_offset_i : sign-extended word offset of the branch
//   jump_target_i   : instr[25:0] word index inside the current 256 MB region
//   next_pc_o       : selected next PC
module next_pc_logic
    import instruction_fetch_pkg::*;
(
    input  logic [XLEN-1:0]      pc_plus4_i,
    input  logic                 jump_i,
    input  logic                 pc_src_i,
    input  logic [XLEN-1:0]      branch_offset_i,
    input  logic [JTARGET_W-1:0] jump_target_i,
    output logic [XLEN-1:0]      next_pc_o
);

    // Priority: jump, then taken branch, then sequential.
    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_i) begin
            next_pc_o = {pc_plus4_i[XLEN-1:XLEN-4], jump_target_i, 2'b00};
        end else if (pc_src_i) begin
            // Word offset scaled to bytes; sum wraps modulo 2^32.
            next_pc_o = pc_plus4_i + (branch_offset_i << 2);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, requests one instruction word at a
// time from instruction memory and presents it to the control stage.
//   clk, reset         : clock, asynchronous active-high reset
//   stall              : hold the current instruction and PC
//   Jump, PCSrc        : control-flow selects, used only when leaving VALID
//   branch_offset      : sign-extended branch word offset
//   jump_target        : instr[25:0] of the current jump
//   imem_ack/imem_rdata: memory response
//   imem_req/imem_addr : memory request, address equals pc
//   pc, pc_plus4       : current instruction address and its successor
//   instr, opcode      : latched instruction word and its opcode field
//   instr_valid        : instr/opcode valid for control
//   fetch_err          : sticky memory-timeout flag
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                Jump,
    input  logic                PCSrc,
    input  logic [31:0]         branch_offset,
    input  logic [25:0]         jump_target,
    input  logic                imem_ack,
    input  logic [31:0]         imem_rdata,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic [31:0]         instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic                instr_valid,
    output logic                fetch_err
);

    localparam int unsigned WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    fetch_state_e      state_q;
    logic [31:0]       pc_q;
    logic [31:0]       instr_q;
    logic [WAIT_W-1:0] wait_q;
    logic              req_q;
    logic              valid_q;
    logic              err_q;
    logic [31:0]       next_pc_d;

    assign pc_plus4 = pc_q + 32'd4;

    next_pc_logic u_next_pc (
        .pc_plus4_i      (pc_plus4),
        .jump_i          (Jump),
        .pc_src_i        (PCSrc),
        .branch_offset_i (branch_offset),
        .jump_target_i   (jump_target),
        .next_pc_o       (next_pc_d)
    );

    // Fetch FSM; every output flag is registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET_S;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            wait_q  <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                RESET_S: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    wait_q  <= '0;
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end else if (wait_q == WAIT_LAST) begin
                        // ACK_TIMEOUT cycles elapsed with no response.
                        wait_q  <= wait_q + WAIT_W'(1);
                        state_q <= ERROR;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                VALID: begin
                    if (!stall) begin
                        pc_q    <= next_pc_d;
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                        wait_q  <= '0;
                    end
                end
                ERROR: begin
                    // Terminal until reset.
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31 -: OPCODE_W];
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

endmodule
